mat_result_serializer: RTL and testbench
========================================

Name: mat_result_serializer

Overview:
- Consumes one packed N*N result matrix per valid_in pulse from the matrix compute unit and streams its elements out one per handshake over a valid/ready interface.
- Sits on the output side of the SIMD datapath, between the mat_mul/add unit and the writeback/output channel.
- Provides the back-pressure the compute unit lacks: upstream sees s_ready and may only present a new result when it is high.

Parameters:
- W_OUT, 32, element width of result and m_data (signed)
- N, 2, matrix dimension (N*N elements per matrix, N >= 1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cen  in  1  clock enable; low freezes all state
- valid_in  in  1  result matrix valid (compute unit valid_out)
- result  in  [N-1:0][N-1:0][W_OUT]  signed packed matrix, [row][col]
- s_ready  out  1  serializer can accept a matrix this cycle
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data
- m_data  out  W_OUT  current element (signed)
- m_row  out  max(1,$clog2(N))  row index of m_data
- m_col  out  max(1,$clog2(N))  column index of m_data
- m_last  out  1  high with the final element of a matrix
- ovf  out  1  only when MAT_SER_OVF_EN is defined

Behaviour:
- Reset (async, rstn=0): state IDLE; m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, element counter=0, holding buffer=0, ovf=0. Any in-progress matrix is discarded immediately.
- States:
  - IDLE: m_valid=0.
  - SEND: m_valid=1.
- s_ready (combinational) = cen && (state==IDLE || (m_valid && m_ready && m_last)).
- Capture: on a posedge with valid_in && s_ready, result is copied into the holding buffer, counter=0, state becomes SEND.
  - Latency: capture at edge t gives m_valid=1 with element [0][0] after edge t.
- Order is row-major: element k = r*N+c and m_data = buffer[r][c]; m_row and m_col are registered with m_data.
- Handshake: an element transfers on a posedge with cen && m_valid && m_ready, and the counter then advances.
  - While m_valid && !m_ready, m_data, m_row, m_col and m_last hold stable.
- m_last = (k == N*N-1). For N=1, every element is last.
- Last element transfers:
  - with no valid_in: go to IDLE and m_valid drops.
  - with valid_in in the same cycle: capture the new matrix and stay in SEND with element [0][0] next cycle. No bubble; sustained throughput is one element per cycle.
- valid_in while s_ready=0: the matrix is dropped. The current stream is unaffected.
- cen=0: no state, counter or buffer updates; m_ready and valid_in are ignored; s_ready=0; outputs hold.
- Arithmetic: no data arithmetic; data passes through at W_OUT. The counter is max(1,$clog2(N*N)) bits wide and wraps to 0 after N*N-1.

Optional Feature:
- Macro: MAT_SER_OVF_EN.
- Defined: the ovf port exists. ovf is a sticky flag set on any cycle with cen && valid_in && !s_ready, and it clears only on reset.
- Undefined: the ovf port and its logic are absent, and dropped matrices are silent.

Decomposition:
- Package mat_ser_pkg holds:
  - the state enum typedef (IDLE, SEND);
  - an index-width function returning max(1,$clog2(x)).
- No sub-module: a single FSM plus counter plus buffer is natural in one module.

Test Plan (N=2, W_OUT=32):
- Single matrix {[0][0]=1,[0][1]=2,[1][0]=3,[1][1]=-4}, one valid_in pulse, m_ready=1 -> m_data 1,2,3,-4 on the four cycles after capture, (row,col) = (0,0),(0,1),(1,0),(1,1), m_last only with -4, s_ready low until the last-element cycle.
- Same matrix with m_ready=0 for 3 cycles while element 2 is presented -> m_data=2, m_col=1 held stable, no loss or duplication, then 3,-4.
- Back-to-back: second matrix {5,6,7,8} with valid_in in the cycle -4 transfers -> 5 presented the very next cycle with m_valid continuously high.
- valid_in with {9,9,9,9} while element 1 of a stream is pending -> 9s never appear, the stream completes unchanged; ovf=1 with MAT_SER_OVF_EN, else no port.
- cen=0 for 2 cycles mid-stream with m_ready=1 -> outputs frozen, no element consumed, s_ready=0; resumes at the same element.
- rstn asserted mid-stream (asynchronously, between edges) -> m_valid=0 immediately, s_ready=1 after release; next matrix streams from [0][0] correctly.

Source files
------------

// File: rtl/mat_result_serializer_pkg.sv
// Shared types and helpers for the matrix result serializer.
// Provides the serializer state encoding and an index-width helper.
package mat_ser_pkg;

    // Serializer is either waiting for a matrix or streaming one out.
    typedef enum logic [0:0] {
        IDLE,
        SEND
    } ser_state_e;

    // Width needed to index x items, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned x);
        if (x <= 1) begin
            return 1;
        end
        return $clog2(x);
    endfunction

endpackage

// File: rtl/mat_result_serializer_if.sv
// Bundle of the upstream matrix handshake and the downstream element stream.
// slave: serializer view. master: environment view (drives matrices, sinks elements).
interface mat_result_serializer_if
    import mat_ser_pkg::*;
#(
    parameter int unsigned W_OUT = 32,
    parameter int unsigned N     = 2
);
    localparam int unsigned IW = idx_w(N);

    // Upstream: one packed [row][col] matrix per accepted valid_in.
    logic                                     valid_in;
    logic signed [N-1:0][N-1:0][W_OUT-1:0]    result;
    logic                                     s_ready;

    // Downstream: one element per valid/ready transfer.
    logic                                     m_valid;
    logic                                     m_ready;
    logic signed [W_OUT-1:0]                  m_data;
    logic        [IW-1:0]                     m_row;
    logic        [IW-1:0]                     m_col;
    logic                                     m_last;

    modport slave (
        input  valid_in,
        input  result,
        output s_ready,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_row,
        output m_col,
        output m_last
    );

    modport master (
        output valid_in,
        output result,
        input  s_ready,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_row,
        input  m_col,
        input  m_last
    );

endinterface

// File: rtl/mat_result_serializer.sv
// Matrix result serializer: captures one N*N result matrix and streams its
// elements row-major over a valid/ready channel, giving the compute unit
// back-pressure through s_ready. The last element may overlap the capture of
// the next matrix, so sustained throughput is one element per cycle.
// Optional: define MAT_SER_OVF_EN to add a sticky ovf flag for dropped matrices.
module mat_result_serializer
    import mat_ser_pkg::*;
#(
    parameter int unsigned W_OUT = 32,
    parameter int unsigned N     = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cen,
`ifdef MAT_SER_OVF_EN
    output logic                    ovf,
`endif
    mat_result_serializer_if.slave  bus
);

    localparam int unsigned IW = idx_w(N);
    localparam int unsigned CW = idx_w(N * N);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] LAST_K   = CW'(N * N - 1);
    localparam logic          ONE_ELEM = (N == 1);

    ser_state_e                       state_q;
    logic [CW-1:0]                    cnt_q;
    logic [N-1:0][N-1:0][W_OUT-1:0]   buf_q;
    logic                             m_valid_q;
    logic [W_OUT-1:0]                 m_data_q;
    logic [IW-1:0]                    m_row_q;
    logic [IW-1:0]                    m_col_q;
    logic                             m_last_q;

    logic                             s_ready;
    logic                             capture;
    logic                             xfer;
    logic [CW-1:0]                    cnt_nxt;
    logic [IW-1:0]                    row_nxt;
    logic [IW-1:0]                    col_nxt;

    // Handshake decode and next row-major position.
    always_comb begin
        s_ready = cen && ((state_q == IDLE) || (m_valid_q && bus.m_ready && m_last_q));
        capture = bus.valid_in && s_ready;
        xfer    = cen && m_valid_q && bus.m_ready;
        cnt_nxt = cnt_q + 1'b1;
        row_nxt = m_row_q;
        col_nxt = m_col_q + 1'b1;
        if (m_col_q == LAST_IDX) begin
            row_nxt = m_row_q + 1'b1;
            col_nxt = '0;
        end
    end

    // FSM, element counter, holding buffer and registered stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_row_q   <= '0;
            m_col_q   <= '0;
            m_last_q  <= 1'b0;
        end else if (cen) begin
            if (capture) begin
                // Covers both the idle start and the no-bubble overlap with the last element.
                state_q   <= SEND;
                cnt_q     <= '0;
                buf_q     <= bus.result;
                m_valid_q <= 1'b1;
                m_data_q  <= bus.result[0][0];
                m_row_q   <= '0;
                m_col_q   <= '0;
                m_last_q  <= ONE_ELEM;
            end else if (xfer) begin
                if (m_last_q) begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end else begin
                    cnt_q    <= cnt_nxt;
                    m_data_q <= buf_q[row_nxt][col_nxt];
                    m_row_q  <= row_nxt;
                    m_col_q  <= col_nxt;
                    m_last_q <= (cnt_nxt == LAST_K);
                end
            end
        end
    end

`ifdef MAT_SER_OVF_EN
    logic ovf_q;

    // Sticky record of any matrix offered while the serializer could not take it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (cen && bus.valid_in && !s_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_row   = m_row_q;
    assign bus.m_col   = m_col_q;
    assign bus.m_last  = m_last_q;

    // A presented element must not change or vanish until it is taken.
    a_stall_stable : assert property (
        @(posedge clk) disable iff (!rstn)
        (m_valid_q && !(cen && bus.m_ready)) |=>
            (m_valid_q && $stable(m_data_q) && $stable(m_row_q) &&
             $stable(m_col_q) && $stable(m_last_q))
    );

    // The counter only ever holds a legal element index.
    a_cnt_range : assert property (
        @(posedge clk) disable iff (!rstn)
        cnt_q <= LAST_K
    );

endmodule

// File: tb/tb_mat_result_serializer.sv
// Directed testbench for mat_result_serializer with N=2, W_OUT=32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mat_result_serializer;

    typedef logic signed [1:0][1:0][31:0] mat_t;

    logic clk = 1'b0;
    logic rstn;
    logic cen;
`ifdef MAT_SER_OVF_EN
    logic ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int exp_a [4] = '{1, 2, 3, -4};
    int exp_b [4] = '{5, 6, 7, 8};

    mat_result_serializer_if #(.W_OUT(32), .N(2)) bus ();

    mat_result_serializer #(
        .W_OUT (32),
        .N     (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .cen  (cen),
`ifdef MAT_SER_OVF_EN
        .ovf  (ovf),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic mat_t mk(input int e00, input int e01, input int e10, input int e11);
        mat_t m;
        m[0][0] = 32'(e00);
        m[0][1] = 32'(e01);
        m[1][0] = 32'(e10);
        m[1][1] = 32'(e11);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle valid_in pulse with m_ready high; returns with [0][0] presented.
    task automatic start(input mat_t m);
        bus.result   = m;
        bus.valid_in = 1'b1;
        bus.m_ready  = 1'b1;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cen = 1'b1;
        bus.valid_in = 1'b0;
        bus.m_ready = 1'b0;
        bus.result = '0;
        tick();
        tick();
        n_tests++;
        if ({bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%0d r=%0d c=%0d l=%b, want all 0",
                     bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last);
        end
        rstn = 1'b1;
        tick();
        n_tests++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got s_ready=%b m_valid=%b, want 1 0",
                     bus.s_ready, bus.m_valid);
        end
`ifdef MAT_SER_OVF_EN
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
    endtask

    task automatic test_single();
        bus.result = mk(1, 2, 3, -4);
        bus.valid_in = 1'b1;
        bus.m_ready = 1'b1;
        n_tests++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_sready_idle: got %b want 1", bus.s_ready);
        end
        tick();
        bus.valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last} !==
                {1'b1, 32'(exp_a[k]), 1'(k / 2), 1'(k % 2), 1'(k == 3)}) begin
                n_fail++;
                $display("FAIL single_elem%0d: got v=%b d=%0d r=%0d c=%0d l=%b, want d=%0d l=%b",
                         k, bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last,
                         exp_a[k], (k == 3));
            end
            n_tests++;
            if (bus.s_ready !== 1'(k == 3)) begin
                n_fail++;
                $display("FAIL single_sready%0d: got %b want %b", k, bus.s_ready, (k == 3));
            end
            tick();
        end
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end_idle: got m_valid=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_backpressure();
        start(mk(1, 2, 3, -4));
        tick();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last} !==
                {1'b1, 32'd2, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b d=%0d r=%0d c=%0d l=%b, want d=2 r=0 c=1",
                         i, bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last);
            end
        end
        bus.m_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            tick();
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 32'(exp_a[k]), 1'(k == 3)}) begin
                n_fail++;
                $display("FAIL bp_resume%0d: got v=%b d=%0d l=%b, want d=%0d",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp_a[k]);
            end
        end
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end_idle: got m_valid=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_back_to_back();
        start(mk(1, 2, 3, -4));
        tick();
        tick();
        tick();
        bus.result = mk(5, 6, 7, 8);
        bus.valid_in = 1'b1;
        n_tests++;
        if (bus.m_data !== -32'sd4 || bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overlap: got d=%0d s_ready=%b, want -4 1", bus.m_data, bus.s_ready);
        end
        tick();
        bus.valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last} !==
                {1'b1, 32'(exp_b[k]), 1'(k / 2), 1'(k % 2), 1'(k == 3)}) begin
                n_fail++;
                $display("FAIL b2b_elem%0d: got v=%b d=%0d r=%0d c=%0d l=%b, want d=%0d",
                         k, bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last, exp_b[k]);
            end
            tick();
        end
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end_idle: got m_valid=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_drop();
        start(mk(1, 2, 3, -4));
        bus.m_ready = 1'b0;
        bus.result = mk(9, 9, 9, 9);
        bus.valid_in = 1'b1;
        n_tests++;
        if (bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_sready: got %b want 0", bus.s_ready);
        end
        tick();
        bus.valid_in = 1'b0;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 32'(exp_a[k]), 1'(k == 3)}) begin
                n_fail++;
                $display("FAIL drop_elem%0d: got v=%b d=%0d l=%b, want d=%0d",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp_a[k]);
            end
            tick();
        end
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_end_idle: got m_valid=%b want 0", bus.m_valid);
        end
`ifdef MAT_SER_OVF_EN
        n_tests++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_ovf: got %b want 1", ovf);
        end
`endif
    endtask

    task automatic test_cen();
        start(mk(1, 2, 3, -4));
        tick();
        cen = 1'b0;
        n_tests++;
        if (bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cen_sready: got %b want 0", bus.s_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_row, bus.m_col} !== {1'b1, 32'd2, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL cen_freeze%0d: got v=%b d=%0d r=%0d c=%0d, want d=2 r=0 c=1",
                         i, bus.m_valid, bus.m_data, bus.m_row, bus.m_col);
            end
        end
        cen = 1'b1;
        for (int k = 2; k < 4; k++) begin
            tick();
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 32'(exp_a[k]), 1'(k == 3)}) begin
                n_fail++;
                $display("FAIL cen_resume%0d: got v=%b d=%0d l=%b, want d=%0d",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp_a[k]);
            end
        end
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cen_end_idle: got m_valid=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_async_reset();
        start(mk(5, 6, 7, 8));
        tick();
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 32'sd0 || bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_immediate: got v=%b d=%0d s_ready=%b, want 0 0 1",
                     bus.m_valid, bus.m_data, bus.s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        n_tests++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_release: got s_ready=%b m_valid=%b, want 1 0",
                     bus.s_ready, bus.m_valid);
        end
`ifdef MAT_SER_OVF_EN
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_ovf: got %b want 0", ovf);
        end
`endif
        start(mk(1, 2, 3, -4));
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last} !==
                {1'b1, 32'(exp_a[k]), 1'(k / 2), 1'(k % 2), 1'(k == 3)}) begin
                n_fail++;
                $display("FAIL arst_elem%0d: got v=%b d=%0d r=%0d c=%0d l=%b, want d=%0d",
                         k, bus.m_valid, bus.m_data, bus.m_row, bus.m_col, bus.m_last, exp_a[k]);
            end
            tick();
        end
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_end_idle: got m_valid=%b want 0", bus.m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_cen();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
